// File: rtl/huffman_cnt_sort_if.sv
// Pixel-in / histogram-and-sort-out bundle between the upstream pixel source and huffman_cnt_sort.
`timescale 1ns/1ps
interface huffman_cnt_sort_if #(
  parameter int CW = 8
);
  logic            gray_valid;
  logic [7:0]      gray_data;
  logic            CNT_valid;
  logic [CW-1:0]   CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
  logic            sort_valid;
  logic [17:0]     sort_sym;
  logic [6*CW-1:0] sort_cnt;

  modport master (
    output gray_valid, gray_data,
    input  CNT_valid, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
    input  sort_valid, sort_sym, sort_cnt
  );

  modport slave (
    input  gray_valid, gray_data,
    output CNT_valid, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
    output sort_valid, sort_sym, sort_cnt
  );
endinterface

// File: rtl/huffman_cnt_sort.sv
// Huffman coder front stage: per-frame histogram of symbols 1..6, then odd-even transposition sort.
// Optional macro HUFF_RANGE_ERR_EN adds a sticky range_err output for symbols outside 1..6.
`timescale 1ns/1ps
module huffman_cnt_sort #(
  parameter int NUM_PIX = 100,
  parameter int CW      = 8
) (
  input  logic               clk,
  input  logic               reset,
  huffman_cnt_sort_if.slave  bus
`ifdef HUFF_RANGE_ERR_EN
  ,
  output logic               range_err
`endif
);

  localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX + 1) : 1;
  localparam logic [PW-1:0] LAST_BEFORE = PW'(NUM_PIX - 1);

  typedef enum logic [1:0] {IDLE, COUNT, LOAD, SORT} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  function automatic logic swap_needed(input logic [2:0] ls, input logic [CW-1:0] lc,
                                       input logic [2:0] rs, input logic [CW-1:0] rc);
    return (rc > lc) || ((rc == lc) && (rs < ls));
  endfunction

  state_t          state;
  logic [PW-1:0]   pixcnt;
  logic [CW-1:0]   cnt_q    [6];
  logic [2:0]      slot_sym [6];
  logic [CW-1:0]   slot_cnt [6];
  logic [2:0]      nxt_sym  [6];
  logic [CW-1:0]   nxt_cnt  [6];
  logic [2:0]      pass_q;
  logic            cnt_valid_q;
  logic            sort_valid_q;
  logic [17:0]     sort_sym_q;
  logic [6*CW-1:0] sort_cnt_q;
  logic            legal;
  logic [2:0]      idx;
  logic            last_pix;

  assign legal    = (bus.gray_data >= 8'd1) && (bus.gray_data <= 8'd6);
  assign idx      = bus.gray_data[2:0] - 3'd1;
  // Pixels already accepted this frame; IDLE counts as zero so NUM_PIX==1 needs no special case.
  assign last_pix = ((state == IDLE) ? '0 : pixcnt) == LAST_BEFORE;

  always_comb begin
    nxt_sym = slot_sym;
    nxt_cnt = slot_cnt;
    for (int i = 0; i < 5; i++) begin
      if ((i[0] == pass_q[0]) &&
          swap_needed(slot_sym[i], slot_cnt[i], slot_sym[i+1], slot_cnt[i+1])) begin
        nxt_sym[i]   = slot_sym[i+1];
        nxt_cnt[i]   = slot_cnt[i+1];
        nxt_sym[i+1] = slot_sym[i];
        nxt_cnt[i+1] = slot_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pixcnt       <= '0;
      pass_q       <= '0;
      cnt_valid_q  <= 1'b0;
      sort_valid_q <= 1'b0;
      sort_sym_q   <= '0;
      sort_cnt_q   <= '0;
      for (int k = 0; k < 6; k++) begin
        cnt_q[k]    <= '0;
        slot_sym[k] <= '0;
        slot_cnt[k] <= '0;
      end
`ifdef HUFF_RANGE_ERR_EN
      range_err    <= 1'b0;
`endif
    end else begin
      cnt_valid_q  <= 1'b0;
      sort_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.gray_valid) begin
            for (int k = 0; k < 6; k++)
              cnt_q[k] <= (legal && (idx == 3'(k))) ? CW'(1) : '0;
            pixcnt <= PW'(1);
`ifdef HUFF_RANGE_ERR_EN
            range_err <= ~legal;
`endif
            if (last_pix) begin
              state       <= LOAD;
              cnt_valid_q <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          if (bus.gray_valid) begin
            for (int k = 0; k < 6; k++)
              if (legal && (idx == 3'(k))) cnt_q[k] <= sat_inc(cnt_q[k]);
            pixcnt <= pixcnt + 1'b1;
`ifdef HUFF_RANGE_ERR_EN
            if (!legal) range_err <= 1'b1;
`endif
            if (last_pix) begin
              state       <= LOAD;
              cnt_valid_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          for (int k = 0; k < 6; k++) begin
            slot_sym[k] <= 3'(k + 1);
            slot_cnt[k] <= cnt_q[k];
          end
          pass_q <= '0;
          state  <= SORT;
        end
        SORT: begin
          slot_sym <= nxt_sym;
          slot_cnt <= nxt_cnt;
          pass_q   <= pass_q + 3'd1;
          // Six passes fully order six slots; publish the result of the last one directly.
          if (pass_q == 3'd5) begin
            for (int k = 0; k < 6; k++) begin
              sort_sym_q[3*k +: 3]   <= nxt_sym[k];
              sort_cnt_q[CW*k +: CW] <= nxt_cnt[k];
            end
            sort_valid_q <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.CNT_valid  = cnt_valid_q;
  assign bus.CNT1       = cnt_q[0];
  assign bus.CNT2       = cnt_q[1];
  assign bus.CNT3       = cnt_q[2];
  assign bus.CNT4       = cnt_q[3];
  assign bus.CNT5       = cnt_q[4];
  assign bus.CNT6       = cnt_q[5];
  assign bus.sort_valid = sort_valid_q;
  assign bus.sort_sym   = sort_sym_q;
  assign bus.sort_cnt   = sort_cnt_q;

endmodule

// File: tb/tb_huffman_cnt_sort.sv
// Directed bench for huffman_cnt_sort: histogram, sort order, gaps, reset, dropped pixels, range error.
`timescale 1ns/1ps
module tb_huffman_cnt_sort;

  logic clk = 1'b0;
  logic reset;
`ifdef HUFF_RANGE_ERR_EN
  logic range_err;
`endif

  huffman_cnt_sort_if #(.CW(8)) bus ();

  huffman_cnt_sort #(.NUM_PIX(100), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef HUFF_RANGE_ERR_EN
    ,
    .range_err (range_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cnt_pulses = 0;
  int sort_pulses = 0;
  int cnt_cyc = 0;
  int sort_cyc = 0;
  int overlap = 0;
  int pc, ps;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.CNT_valid)  begin cnt_pulses++;  cnt_cyc  = cyc; end
    if (bus.sort_valid) begin sort_pulses++; sort_cyc = cyc; end
    if (bus.CNT_valid && bus.sort_valid) overlap++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    bus.gray_valid = 1'b1;
    bus.gray_data  = d;
    @(posedge clk); #1;
    bus.gray_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send(d);
  endtask

  task automatic wait_sort(input int prev);
    for (int i = 0; i < 20 && sort_pulses == prev; i++) begin
      @(posedge clk); #1;
    end
    chk("sort_done", sort_pulses, prev + 1);
  endtask

  // Distribution 1:10, 2:20, 3:30, 4:15, 5:5, 6:20 over pixel index 0..99
  function automatic logic [7:0] t2_sym(input int i);
    if (i < 10) return 8'd1;
    if (i < 30) return 8'd2;
    if (i < 60) return 8'd3;
    if (i < 75) return 8'd4;
    if (i < 80) return 8'd5;
    return 8'd6;
  endfunction

  function automatic logic [47:0] cnts();
    return {bus.CNT6, bus.CNT5, bus.CNT4, bus.CNT3, bus.CNT2, bus.CNT1};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.gray_valid = 1'b0;
    bus.gray_data  = 8'd0;
    repeat (3) @(posedge clk); #1;
    chk("rst_cnts", cnts(), 48'd0);
    chk("rst_sort_sym", bus.sort_sym, 18'd0);
    chk("rst_sort_cnt", bus.sort_cnt, 48'd0);
    chk("rst_valids", {bus.CNT_valid, bus.sort_valid}, 2'b00);
    reset = 1'b1;
    @(posedge clk); #1;

    // T1: single symbol
    pc = cnt_pulses; ps = sort_pulses;
    send_n(8'd3, 100);
    wait_sort(ps);
    chk("t1_cnts", cnts(), {8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0});
    chk("t1_sort_sym", bus.sort_sym, {3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd3});
    chk("t1_sort_cnt", bus.sort_cnt, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100});
    chk("t1_cnt_pulses", cnt_pulses - pc, 1);

    // T2: mixed counts with a 2/6 tie
    pc = cnt_pulses; ps = sort_pulses;
    for (int i = 0; i < 100; i++) send(t2_sym(i));
    wait_sort(ps);
    chk("t2_cnts", cnts(), {8'd20, 8'd5, 8'd15, 8'd30, 8'd20, 8'd10});
    chk("t2_sort_sym", bus.sort_sym, {3'd5, 3'd1, 3'd4, 3'd6, 3'd2, 3'd3});
    chk("t2_sort_cnt", bus.sort_cnt, {8'd5, 8'd10, 8'd15, 8'd20, 8'd20, 8'd30});
    chk("t2_latency", sort_cyc - cnt_cyc, 7);
    chk("t2_cnt_pulses", cnt_pulses - pc, 1);

    // T3: same frame with idle gaps
    pc = cnt_pulses; ps = sort_pulses;
    for (int i = 0; i < 100; i++) begin
      if (i == 99) chk("t3_no_early_valid", cnt_pulses - pc, 0);
      send(t2_sym(i));
      if (i != 99) repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
    end
    wait_sort(ps);
    chk("t3_cnts", cnts(), {8'd20, 8'd5, 8'd15, 8'd30, 8'd20, 8'd10});
    chk("t3_sort_sym", bus.sort_sym, {3'd5, 3'd1, 3'd4, 3'd6, 3'd2, 3'd3});
    chk("t3_cnt_pulses", cnt_pulses - pc, 1);

    // T4: reset mid-frame
    send_n(8'd5, 40);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t4_rst_cnts", cnts(), 48'd0);
    chk("t4_rst_sort_sym", bus.sort_sym, 18'd0);
    chk("t4_rst_sort_cnt", bus.sort_cnt, 48'd0);
    chk("t4_rst_valids", {bus.CNT_valid, bus.sort_valid}, 2'b00);
    reset = 1'b1;
    @(posedge clk); #1;
    pc = cnt_pulses; ps = sort_pulses;
    send_n(8'd2, 100);
    wait_sort(ps);
    chk("t4_cnts", cnts(), {8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd0});
    chk("t4_sort_sym", bus.sort_sym, {3'd6, 3'd5, 3'd4, 3'd3, 3'd1, 3'd2});
    chk("t4_cnt_pulses", cnt_pulses - pc, 1);

    // T5: pixels offered during LOAD/SORT are dropped
    pc = cnt_pulses; ps = sort_pulses;
    send_n(8'd4, 100);
    bus.gray_valid = 1'b1;
    bus.gray_data  = 8'd1;
    repeat (7) @(posedge clk);
    #1;
    bus.gray_valid = 1'b0;
    wait_sort(ps);
    chk("t5_cnts", cnts(), {8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0});
    chk("t5_sort_sym", bus.sort_sym, {3'd6, 3'd5, 3'd3, 3'd2, 3'd1, 3'd4});
    chk("t5_sort_cnt", bus.sort_cnt, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100});
    chk("t5_cnt_pulses", cnt_pulses - pc, 1);
    pc = cnt_pulses; ps = sort_pulses;
    send_n(8'd6, 100);
    wait_sort(ps);
    chk("t5_next_cnts", cnts(), {8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    chk("t5_next_sort_sym", bus.sort_sym, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd6});

`ifdef HUFF_RANGE_ERR_EN
    // T6: out-of-range symbol at pixel 50
    ps = sort_pulses;
    for (int i = 0; i < 100; i++) begin
      send((i == 49) ? 8'd9 : 8'd3);
      if (i == 0)  chk("t6_err_clear", range_err, 1'b0);
      if (i == 49) chk("t6_err_set", range_err, 1'b1);
    end
    wait_sort(ps);
    chk("t6_cnts", cnts(), {8'd0, 8'd0, 8'd0, 8'd99, 8'd0, 8'd0});
    chk("t6_err_sticky", range_err, 1'b1);
    ps = sort_pulses;
    send(8'd3);
    chk("t6_err_next_frame", range_err, 1'b0);
    send_n(8'd3, 99);
    wait_sort(ps);
`endif

    chk("no_overlap", overlap, 0);
    chk("pulse_balance", cnt_pulses, sort_pulses);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
